// File: rtl/md_unit_pkg.sv
// Shared op codes, FSM states and latency-class helpers for the multiply/divide unit.
// Also used by the instruction decoder and the hazard unit.
package md_unit_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MADD  = 4'd5,
    MD_MADDU = 4'd6,
    MD_MSUB  = 4'd7,
    MD_MSUBU = 4'd8,
    MD_MTHI  = 4'd9,
    MD_MTLO  = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_mul_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage issue bus into the multiply/divide unit plus its busy/HI/LO return path.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic                               start;
  logic [md_unit_pkg::MD_OP_W-1:0]    op;
  logic [WIDTH-1:0]                   a;
  logic [WIDTH-1:0]                   b;
  logic                               cancel;
  logic                               busy;
  logic [WIDTH-1:0]                   hi;
  logic [WIDTH-1:0]                   lo;

  modport master (output start, op, a, b, cancel, input busy, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, hi, lo);
endinterface

// File: rtl/md_unit_arith.sv
// Combinational multiply / multiply-accumulate / divide producing the next {HI,LO}.
// Zero latency; divide-by-zero and signed-overflow corner cases resolved here.
module md_unit_arith
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0] i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);
  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             w_sgn;
  logic             w_neg_a;
  logic             w_neg_b;
  logic             w_ovf;
  logic [W2-1:0]    w_a_ext;
  logic [W2-1:0]    w_b_ext;
  logic [W2-1:0]    w_prod;
  logic [W2-1:0]    w_acc;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_dvsr;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  assign w_sgn   = (i_op == MD_MULT) || (i_op == MD_MADD) ||
                   (i_op == MD_MSUB) || (i_op == MD_DIV);
  assign w_a_ext = w_sgn ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
  assign w_b_ext = w_sgn ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_acc   = {i_hi, i_lo};

  // Signed divide runs on magnitudes through the single unsigned divider.
  assign w_neg_a = w_sgn & i_a[WIDTH-1];
  assign w_neg_b = w_sgn & i_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -i_a : i_a;
  assign w_mag_b = w_neg_b ? -i_b : i_b;
  assign w_dvsr  = (i_b == '0) ? WIDTH'(1) : w_mag_b;
  assign w_q_mag = w_mag_a / w_dvsr;
  assign w_r_mag = w_mag_a % w_dvsr;
  assign w_q     = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
  assign w_r     = w_neg_a ? -w_r_mag : w_r_mag;
  assign w_ovf   = w_sgn && (i_a == MOST_NEG) && (i_b == '1);

  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    case (i_op)
      MD_MULT, MD_MULTU: {o_hi, o_lo} = w_prod;
      MD_MADD, MD_MADDU: {o_hi, o_lo} = w_acc + w_prod;
      MD_MSUB, MD_MSUBU: {o_hi, o_lo} = w_acc - w_prod;
      MD_DIV, MD_DIVU: begin
        if (i_b == '0) begin
          o_lo = '1;
          o_hi = i_a;
        end else if (w_ovf) begin
          o_lo = i_a;
          o_hi = '0;
        end else begin
          o_lo = w_q;
          o_hi = w_r;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO; results commit MUL_LAT/DIV_LAT edges after issue.
// Busy is registered; starts while busy or alongside cancel are dropped, the hazard unit must stall.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  md_unit_if.slave     io
);
  localparam logic [CNT_W-1:0] L_MUL = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] L_DIV = CNT_W'(DIV_LAT);

  md_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_pend_hi, w_pend_hi_nxt;
  logic [WIDTH-1:0] r_pend_lo, w_pend_lo_nxt;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_accept;

  md_unit_arith #(.WIDTH(WIDTH)) u_arith (
    .i_op (io.op),
    .i_a  (io.a),
    .i_b  (io.b),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo)
  );

  assign w_accept = io.start && !io.cancel && (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_mul_op(io.op) || is_div_op(io.op)) begin
            w_pend_hi_nxt = w_res_hi;
            w_pend_lo_nxt = w_res_lo;
            w_cnt_nxt     = is_mul_op(io.op) ? L_MUL : L_DIV;
            w_state_nxt   = ST_BUSY;
          end else if (io.op == MD_MTHI) begin
            w_hi_nxt = io.a;
          end else if (io.op == MD_MTLO) begin
            w_lo_nxt = io.a;
          end
        end
      end
      ST_BUSY: begin
        // Cancel takes priority even on the commit edge.
        if (io.cancel) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_pend_hi_nxt = '0;
          w_pend_lo_nxt = '0;
        end else if (r_cnt == CNT_W'(1)) begin
          w_hi_nxt    = r_pend_hi;
          w_lo_nxt    = r_pend_lo;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
    end
  end

  assign io.busy = (r_state == ST_BUSY);
  assign io.hi   = r_hi;
  assign io.lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: 32-bit default instance plus a 16-bit, MUL_LAT=1, DIV_LAT=3 instance.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  md_unit_if #(.WIDTH(32)) m32 ();
  md_unit_if #(.WIDTH(16)) m16 ();

  md_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) u32 (
    .clk   (clk),
    .reset (reset),
    .io    (m32)
  );

  md_unit #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3), .CNT_W(2)) u16 (
    .clk   (clk),
    .reset (reset),
    .io    (m16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic st, input logic [3:0] o,
                       input logic [31:0] av, input logic [31:0] bv, input logic cn);
    if (d == 0) begin
      m32.start = st; m32.op = o; m32.a = av; m32.b = bv; m32.cancel = cn;
    end else begin
      m16.start = st; m16.op = o; m16.a = av[15:0]; m16.b = bv[15:0]; m16.cancel = cn;
    end
  endtask

  function automatic logic get_busy(input int d);
    return (d == 0) ? m32.busy : m16.busy;
  endfunction

  function automatic logic [31:0] get_hi(input int d);
    return (d == 0) ? m32.hi : {16'h0, m16.hi};
  endfunction

  function automatic logic [31:0] get_lo(input int d);
    return (d == 0) ? m32.lo : {16'h0, m16.lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hl(input int d, input string tag, input logic [31:0] eh, input logic [31:0] el);
    chk({tag, "_hi"}, get_hi(d), eh);
    chk({tag, "_lo"}, get_lo(d), el);
  endtask

  // Counts edges with busy high (cyc0 already elapsed), then checks latency and HI/LO.
  task automatic finish_op(input int d, input int cyc0, input int lat,
                           input logic [31:0] eh, input logic [31:0] el, input string tag);
    int cyc;
    cyc = cyc0;
    while (get_busy(d) && cyc < 64) begin
      cyc++;
      tick();
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk_hl(d, tag, eh, el);
  endtask

  task automatic op_run(input int d, input logic [3:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int lat,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    drive(d, 1'b1, o, av, bv, 1'b0);
    tick();
    drive(d, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    finish_op(d, 0, lat, eh, el, tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(0, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'h0, m32.busy}, 32'h0);
    chk_hl(0, "rst", 32'h0, 32'h0);

    // Multiply family and accumulate wrap
    op_run(0, MD_MULT,  32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    op_run(0, MD_MULTU, 32'hFFFF_FFFF, 32'h2, 5, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    op_run(0, MD_DIV,   32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    op_run(0, MD_DIVU,  32'h7, 32'h0, 10, 32'h7, 32'hFFFF_FFFF, "divu_zero");
    op_run(0, MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, "div_ovf");
    op_run(0, MD_DIV,   32'hFFFF_FFF9, 32'h0, 10, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero");
    op_run(0, MD_MTHI,  32'h5, 32'h0, 0, 32'h5, 32'hFFFF_FFFF, "mthi");
    op_run(0, MD_MTLO,  32'h3, 32'h0, 0, 32'h5, 32'h3, "mtlo");
    op_run(0, MD_MADDU, 32'h2, 32'h4, 5, 32'h5, 32'hB, "maddu");
    op_run(0, MD_MSUB,  32'h1, 32'hC, 5, 32'h4, 32'hFFFF_FFFF, "msub");
    op_run(0, MD_MADD,  32'hFFFF_FFFF, 32'h1, 5, 32'h4, 32'hFFFF_FFFE, "madd_neg");
    op_run(0, MD_MTHI,  32'h0, 32'h0, 0, 32'h0, 32'hFFFF_FFFE, "mthi0");
    op_run(0, MD_MTLO,  32'h0, 32'h0, 0, 32'h0, 32'h0, "mtlo0");
    op_run(0, MD_MSUBU, 32'h1, 32'h1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "msubu_wrap");
    op_run(0, 4'hF,     32'h1, 32'h1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "undef_op");

    // Cancel in busy cycle 4 of a divide; the pending result must never land
    drive(0, 1'b1, MD_DIV, 32'd100, 32'd7, 1'b0);
    tick();
    drive(0, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    tick(); tick(); tick();
    drive(0, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b1);
    tick();
    drive(0, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    chk("cancel_busy", {31'h0, m32.busy}, 32'h0);
    for (int i = 0; i < 12; i++) tick();
    chk_hl(0, "cancel_hold", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Start together with cancel while idle is dropped
    drive(0, 1'b1, MD_MTHI, 32'h7, 32'h0, 1'b1);
    tick();
    drive(0, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    chk("start_cancel_hi", m32.hi, 32'hFFFF_FFFF);

    // Cancel on the commit edge wins
    drive(0, 1'b1, MD_MULT, 32'h3, 32'h3, 1'b0);
    tick();
    drive(0, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    tick(); tick(); tick(); tick();
    chk("pre_commit_busy", {31'h0, m32.busy}, 32'h1);
    drive(0, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b1);
    tick();
    drive(0, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    chk("cancel_edge_busy", {31'h0, m32.busy}, 32'h0);
    chk_hl(0, "cancel_edge", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Start while busy is ignored, then back-to-back issue at the first idle cycle
    drive(0, 1'b1, MD_MULT, 32'h3, 32'h4, 1'b0);
    tick();
    drive(0, 1'b1, MD_MTHI, 32'hDEAD, 32'h0, 1'b0);
    tick();
    drive(0, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    chk("busy_start_hi", m32.hi, 32'hFFFF_FFFF);
    finish_op(0, 1, 5, 32'h0, 32'hC, "busy_start");
    op_run(0, MD_MULT, 32'h5, 32'h6, 5, 32'h0, 32'h1E, "b2b");

    // Reset in the middle of a divide discards it
    drive(0, 1'b1, MD_DIV, 32'd100, 32'd7, 1'b0);
    tick();
    drive(0, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", {31'h0, m32.busy}, 32'h0);
    chk_hl(0, "mid_rst", 32'h0, 32'h0);
    for (int i = 0; i < 12; i++) tick();
    chk_hl(0, "mid_rst_hold", 32'h0, 32'h0);

    // 16-bit instance with MUL_LAT=1, DIV_LAT=3
    op_run(1, MD_MULT,  32'hFFFF, 32'h2, 1, 32'hFFFF, 32'hFFFE, "w16_mult");
    op_run(1, MD_DIV,   32'hFFF9, 32'h2, 3, 32'hFFFF, 32'hFFFD, "w16_div_neg");
    op_run(1, MD_DIVU,  32'h7, 32'h0, 3, 32'h7, 32'hFFFF, "w16_divu_zero");
    op_run(1, MD_DIV,   32'h8000, 32'hFFFF, 3, 32'h0, 32'h8000, "w16_div_ovf");
    op_run(1, MD_MTHI,  32'h5, 32'h0, 0, 32'h5, 32'h8000, "w16_mthi");
    op_run(1, MD_MTLO,  32'h3, 32'h0, 0, 32'h5, 32'h3, "w16_mtlo");
    op_run(1, MD_MADDU, 32'h2, 32'h4, 1, 32'h5, 32'hB, "w16_maddu");
    op_run(1, MD_MSUB,  32'h1, 32'hC, 1, 32'h4, 32'hFFFF, "w16_msub");
    drive(1, 1'b1, MD_DIV, 32'd100, 32'd7, 1'b0);
    tick();
    drive(1, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    drive(1, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1, 1'b0, MD_NOP, 32'h0, 32'h0, 1'b0);
    chk("w16_cancel_busy", {31'h0, m16.busy}, 32'h0);
    chk_hl(1, "w16_cancel", 32'h4, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
